// File: rtl/esc_pkg.sv
// ---------------------------------------------------------------------------
// esc_pkg
// Shared definitions for the ESC setpoint ramp controller: the 2-bit state
// encoding, default ramp parameters, datapath widths and a small helper that
// maps a zero step request onto the smallest legal step.
// ---------------------------------------------------------------------------
package esc_pkg;

    // Controller states. The encoding is also exposed on the debug port of
    // setpoint_ramp_ctrl so checkers can bind to it directly.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RAMP  = 2'd2,
        ST_HOLD  = 2'd3
    } esc_state_e;

    // Slowest speed: the largest commutation period the datapath accepts.
    localparam logic [15:0] START_PERIOD_DEFAULT = 16'hFFFF;

    // Number of cycles the tuner-reset strobe stays high before ramping.
    localparam int PRIME_CYCLES_DEFAULT = 4;

    localparam int PERIOD_W    = 16;
    localparam int STEP_W      = 8;
    localparam int DWELL_W     = 16;
    localparam int PRIME_CNT_W = 4;

    // A step of zero would stall the ramp forever, so it is promoted to 1.
    function automatic logic [STEP_W-1:0] effective_step(input logic [STEP_W-1:0] s);
        return (s == '0) ? STEP_W'(1) : s;
    endfunction

endpackage

// File: rtl/ramp_step_unit.sv
// ---------------------------------------------------------------------------
// ramp_step_unit
// Combinational saturating "one step toward target" calculation.
//
// Ports
//   current   in  16  present setpoint
//   target    in  16  final setpoint
//   step      in  8   requested step magnitude (0 is treated as 1)
//   next      out 16  setpoint after one update
//   at_target out 1   next equals target
//
// The distance is evaluated in 17 bits so neither direction can wrap: if the
// remaining distance is within one step the result lands exactly on target,
// otherwise the setpoint moves by a full step, which by construction stays
// strictly between current and target.
// ---------------------------------------------------------------------------
module ramp_step_unit
    import esc_pkg::*;
(
    input  logic [PERIOD_W-1:0] current,
    input  logic [PERIOD_W-1:0] target,
    input  logic [STEP_W-1:0]   step,
    output logic [PERIOD_W-1:0] next,
    output logic                at_target
);

    logic [PERIOD_W:0] cur_ext;
    logic [PERIOD_W:0] tgt_ext;
    logic [PERIOD_W:0] step_ext;
    logic [PERIOD_W:0] distance;
    logic [PERIOD_W:0] next_ext;
    logic              rising;

    always_comb begin
        cur_ext  = {1'b0, current};
        tgt_ext  = {1'b0, target};
        step_ext = {{(PERIOD_W + 1 - STEP_W){1'b0}}, effective_step(step)};
        rising   = 1'b0;
        distance = '0;
        next_ext = cur_ext;

        if (tgt_ext >= cur_ext) begin
            rising   = 1'b1;
            distance = tgt_ext - cur_ext;
        end else begin
            distance = cur_ext - tgt_ext;
        end

        if (distance <= step_ext) begin
            next_ext = tgt_ext;
        end else if (rising) begin
            next_ext = cur_ext + step_ext;
        end else begin
            next_ext = cur_ext - step_ext;
        end
    end

    assign next      = next_ext[PERIOD_W-1:0];
    assign at_target = (next_ext == tgt_ext);

endmodule

// File: rtl/setpoint_ramp_ctrl.sv
// ---------------------------------------------------------------------------
// setpoint_ramp_ctrl
// Soft-start controller for the ESC. From rest it pulses the PID/autotune
// reset, then walks period_reference from START_PERIOD toward a requested
// target in fixed steps, one step every (dwell + 1) cycles, and holds there.
//
// Ports
//   clk              in  1   system clock, rising edge
//   rst              in  1   synchronous active-high reset
//   start            in  1   one-cycle request; latches target/step/dwell
//   abort            in  1   level; motor off, back to IDLE (beats start)
//   target_period    in  16  final period_reference
//   step             in  8   change per update (0 acts as 1)
//   dwell            in  16  cycles between updates, minus one
//   period_reference out 16  setpoint to the PID datapath
//   pwm_en           out 1   motor drive enable
//   tunerreset       out 1   PID/autotune reset strobe
//   busy             out 1   high in PRIME or RAMP
//   done             out 1   one-cycle pulse when the setpoint hits target
//   state_dbg        out 2   current FSM state (esc_state_e encoding)
//
// All outputs are registered. done is raised by the same edge that writes
// the final setpoint, so it is seen the cycle after the last update tick,
// together with state HOLD.
// ---------------------------------------------------------------------------
module setpoint_ramp_ctrl
    import esc_pkg::*;
#(
    parameter logic [15:0] START_PERIOD = START_PERIOD_DEFAULT,
    parameter int          PRIME_CYCLES = PRIME_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] target_period,
    input  logic [STEP_W-1:0]   step,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [PERIOD_W-1:0] period_reference,
    output logic                pwm_en,
    output logic                tunerreset,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state_dbg
);

    // Last PRIME cycle index; tunerreset is high for PRIME_CYCLES cycles.
    localparam logic [PRIME_CNT_W-1:0] PRIME_LAST = PRIME_CNT_W'(PRIME_CYCLES - 1);

    esc_state_e               state;
    logic [PRIME_CNT_W-1:0]   prime_cnt;
    logic [DWELL_W-1:0]       dwell_cnt;
    logic [PERIOD_W-1:0]      target_l;
    logic [STEP_W-1:0]        step_l;
    logic [DWELL_W-1:0]       dwell_l;

    logic [PERIOD_W-1:0]      step_next;
    logic                     step_at_target;
    logic                     update_tick;

    ramp_step_unit u_step (
        .current   (period_reference),
        .target    (target_l),
        .step      (step_l),
        .next      (step_next),
        .at_target (step_at_target)
    );

    // The dwell counter wraps at the latched dwell; that wrap is the update.
    assign update_tick = (dwell_cnt == dwell_l);
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            period_reference <= START_PERIOD;
            pwm_en           <= 1'b0;
            tunerreset       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            prime_cnt        <= '0;
            dwell_cnt        <= '0;
            target_l         <= '0;
            step_l           <= '0;
            dwell_l          <= '0;
        end else if (abort) begin
            // Motor off immediately; latched request values are left alone,
            // a fresh start overwrites them anyway.
            state            <= ST_IDLE;
            period_reference <= START_PERIOD;
            pwm_en           <= 1'b0;
            tunerreset       <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            prime_cnt        <= '0;
            dwell_cnt        <= '0;
        end else begin
            done <= 1'b0;

            // start re-latches the request in every state. An update tick in
            // the same cycle still uses the previous request.
            if (start) begin
                target_l <= target_period;
                step_l   <= step;
                dwell_l  <= dwell;
            end

            case (state)
                ST_IDLE: begin
                    period_reference <= START_PERIOD;
                    pwm_en           <= 1'b0;
                    busy             <= 1'b0;
                    tunerreset       <= 1'b0;
                    if (start) begin
                        state      <= ST_PRIME;
                        pwm_en     <= 1'b1;
                        busy       <= 1'b1;
                        tunerreset <= 1'b1;
                        prime_cnt  <= '0;
                    end
                end

                ST_PRIME: begin
                    if (prime_cnt == PRIME_LAST) begin
                        state      <= ST_RAMP;
                        tunerreset <= 1'b0;
                        prime_cnt  <= '0;
                        dwell_cnt  <= '0;
                    end else begin
                        prime_cnt <= prime_cnt + 1'b1;
                    end
                end

                ST_RAMP: begin
                    // A retarget here deliberately leaves dwell_cnt running so
                    // the update cadence is not disturbed.
                    if (update_tick) begin
                        dwell_cnt        <= '0;
                        period_reference <= step_next;
                        if (step_at_target) begin
                            state <= ST_HOLD;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end

                ST_HOLD: begin
                    // Motor is already spinning: skip PRIME and ramp from the
                    // held setpoint.
                    if (start) begin
                        state     <= ST_RAMP;
                        busy      <= 1'b1;
                        dwell_cnt <= '0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_setpoint_ramp_ctrl.sv
module tb_setpoint_ramp_ctrl;
  import esc_pkg::*;

  localparam int PRIME_N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] target_period = '0;
  logic [7:0]  step = '0;
  logic [15:0] dwell = '0;
  logic [15:0] period_reference;
  logic        pwm_en;
  logic        tunerreset;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  setpoint_ramp_ctrl #(
    .START_PERIOD (16'hFFFF),
    .PRIME_CYCLES (PRIME_N)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .target_period    (target_period),
    .step             (step),
    .dwell            (dwell),
    .period_reference (period_reference),
    .pwm_en           (pwm_en),
    .tunerreset       (tunerreset),
    .busy             (busy),
    .done             (done),
    .state_dbg        (state_dbg)
  );

  int total = 0;
  int bad = 0;
  logic [15:0] model_sp = 16'hFFFF;  // setpoint the reference model believes is current
  logic [15:0] exp_q[$];             // expected setpoint after each update tick

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Outputs are sampled 1 time unit after the rising edge; inputs change
  // at that same point, well away from the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] t, input logic [7:0] s, input logic [15:0] d);
    target_period = t;
    step = s;
    dwell = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Builds the setpoint trajectory from model_sp to tgt: each update moves a
  // full effective step unless the target is within reach, then lands on it.
  task automatic build_traj(input logic [15:0] tgt, input logic [7:0] stp);
    int c;
    int t;
    int s;
    c = int'(model_sp);
    t = int'(tgt);
    s = (stp == 8'd0) ? 1 : int'(stp);
    exp_q.delete();
    do begin
      if (t >= c) c = (t - c <= s) ? t : c + s;
      else        c = (c - t <= s) ? t : c - s;
      exp_q.push_back(16'(c));
    end while (c != t);
  endtask

  // Checks PRIME_N cycles of tuner reset with the motor enabled at model_sp.
  task automatic check_prime();
    for (int i = 0; i < PRIME_N; i++) begin
      total++;
      if ({tunerreset, pwm_en, busy, done, period_reference} !== {1'b1, 1'b1, 1'b1, 1'b0, model_sp}) begin
        bad++;
        $display("FAIL prime[%0d]: tr/pwm/busy/done/sp got %b%b%b%b %h required 1110 %h",
                 i, tunerreset, pwm_en, busy, done, period_reference, model_sp);
        return;
      end
      tick();
    end
  endtask

  // Follows a ramp from the current sample. first_wait is the number of
  // samples before the first update; at most max_upd updates are followed.
  task automatic check_ramp(input logic [15:0] tgt, input logic [7:0] stp, input logic [15:0] dw,
                            input int first_wait, input int max_upd, output bit reached);
    int n;
    reached = 1'b0;
    build_traj(tgt, stp);
    n = exp_q.size();
    for (int k = 0; k < n && k < max_upd; k++) begin
      int w;
      w = (k == 0) ? first_wait : int'(dw) + 1;
      for (int j = 0; j < w; j++) begin
        total++;
        if ({pwm_en, busy, tunerreset, done, period_reference} !== {1'b1, 1'b1, 1'b0, 1'b0, model_sp}) begin
          bad++;
          $display("FAIL ramp_upd%0d_cyc%0d: pwm/busy/tr/done/sp got %b%b%b%b %h required 1100 %h",
                   k, j, pwm_en, busy, tunerreset, done, period_reference, model_sp);
          return;
        end
        tick();
      end
      model_sp = exp_q[k];
    end
    if (max_upd < n) return;
    total++;
    if ({pwm_en, busy, done, period_reference, state_dbg} !== {1'b1, 1'b0, 1'b1, tgt, ST_HOLD}) begin
      bad++;
      $display("FAIL ramp_done: pwm/busy/done/sp/state got %b%b%b %h %0d required 101 %h %0d",
               pwm_en, busy, done, period_reference, state_dbg, tgt, ST_HOLD);
      return;
    end
    tick();
    total++;
    if ({pwm_en, busy, done, period_reference} !== {1'b1, 1'b0, 1'b0, tgt}) begin
      bad++;
      $display("FAIL hold_after_done: pwm/busy/done/sp got %b%b%b %h required 100 %h",
               pwm_en, busy, done, period_reference, tgt);
      return;
    end
    reached = 1'b1;
  endtask

  task automatic check_reset_values(input string name);
    total++;
    if ({period_reference, pwm_en, tunerreset, busy, done, state_dbg} !==
        {16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE}) begin
      bad++;
      $display("FAIL %s: sp/pwm/tr/busy/done/state got %h %b%b%b%b %0d required ffff 0000 %0d",
               name, period_reference, pwm_en, tunerreset, busy, done, state_dbg, ST_IDLE);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    check_reset_values("idle_after_reset");
    model_sp = 16'hFFFF;
  endtask

  task automatic test_basic_ramp();
    bit r;
    do_start(16'h1000, 8'h40, 16'd0);
    check_prime();
    check_ramp(16'h1000, 8'h40, 16'd0, 1, 1 << 20, r);
  endtask

  task automatic test_hold_retarget();
    bit r;
    do_start(16'h1005, 8'd8, 16'd3);
    check_ramp(16'h1005, 8'd8, 16'd3, 4, 1 << 20, r);
  endtask

  task automatic test_abort();
    bit r;
    do_start(16'h0100, 8'd1, 16'd0);
    check_ramp(16'h0100, 8'd1, 16'd0, 1, 5, r);
    abort = 1'b1;
    start = 1'b1;
    target_period = 16'h2000;
    tick();
    start = 1'b0;
    check_reset_values("abort_with_start");
    abort = 1'b0;
    tick();
    check_reset_values("idle_after_abort");
    model_sp = 16'hFFFF;
  endtask

  task automatic test_step_zero();
    bit r;
    do_start(16'hFFFC, 8'd0, 16'd1);
    check_prime();
    build_traj(16'hFFFC, 8'd0);
    total++;
    if (exp_q.size() != 3) begin
      bad++;
      $display("FAIL step_zero_updates: model gives %0d updates required 3", exp_q.size());
    end
    check_ramp(16'hFFFC, 8'd0, 16'd1, 2, 1 << 20, r);
  endtask

  task automatic test_retarget_reverse();
    bit r;
    logic [15:0] new_t;
    do_start(16'h8000, 8'h10, 16'd2);
    check_ramp(16'h8000, 8'h10, 16'd2, 3, 4, r);
    // Now on the first cycle after an update; retarget above the setpoint.
    new_t = model_sp + 16'h0025;
    total++;
    if (period_reference !== model_sp) begin
      bad++;
      $display("FAIL retarget_pre: sp got %h required %h", period_reference, model_sp);
    end
    do_start(new_t, 8'h10, 16'd2);
    check_ramp(new_t, 8'h10, 16'd2, 2, 1 << 20, r);
  endtask

  task automatic test_saturation();
    bit r;
    do_start(16'hFFFF, 8'd255, 16'd0);
    check_ramp(16'hFFFF, 8'd255, 16'd0, 1, 1 << 20, r);
    do_start(16'h0000, 8'd255, 16'd0);
    check_ramp(16'h0000, 8'd255, 16'd0, 1, 1 << 20, r);
    // Target equal to the current setpoint: done on the first update tick.
    do_start(16'h0000, 8'd7, 16'd0);
    check_ramp(16'h0000, 8'd7, 16'd0, 1, 1 << 20, r);
  endtask

  task automatic test_reset_mid_ramp();
    bit r;
    do_start(16'h0500, 8'h20, 16'd1);
    check_ramp(16'h0500, 8'h20, 16'd1, 2, 3, r);
    tick();
    // This sample is an update-tick cycle; reset must win over the update.
    rst = 1'b1;
    tick();
    check_reset_values("reset_mid_ramp");
    rst = 1'b0;
    tick();
    check_reset_values("idle_after_mid_reset");
    model_sp = 16'hFFFF;
  endtask

  task automatic test_reset_prime();
    bit r;
    do_start(16'h1000, 8'h40, 16'd0);
    tick();
    total++;
    if (tunerreset !== 1'b1) begin
      bad++;
      $display("FAIL prime_before_reset: tr got %b required 1", tunerreset);
    end
    rst = 1'b1;
    tick();
    check_reset_values("reset_in_prime");
    rst = 1'b0;
    tick();
    model_sp = 16'hFFFF;
    do_start(16'h1000, 8'h40, 16'd0);
    check_prime();
    check_ramp(16'h1000, 8'h40, 16'd0, 1, 1 << 20, r);
  endtask

  task automatic test_random();
    bit r;
    bit from_idle;
    for (int it = 0; it < 10; it++) begin
      logic [7:0]  s;
      logic [15:0] d;
      int seff;
      int t;
      from_idle = (it % 3 == 0);
      if (from_idle) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        model_sp = 16'hFFFF;
      end
      s = 8'($urandom_range(0, 255));
      d = 16'($urandom_range(0, 3));
      seff = (s == 8'd0) ? 1 : int'(s);
      if ($urandom_range(0, 1) == 1) t = int'(model_sp) + int'($urandom_range(0, seff * 30));
      else                           t = int'(model_sp) - int'($urandom_range(0, seff * 30));
      if (t < 0) t = 0;
      if (t > 65535) t = 65535;
      do_start(16'(t), s, d);
      if (from_idle) check_prime();
      check_ramp(16'(t), s, d, int'(d) + 1, 1 << 20, r);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_ramp();
    test_hold_retarget();
    test_abort();
    test_step_zero();
    test_retarget_reverse();
    test_saturation();
    test_reset_mid_ramp();
    test_reset_prime();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
